// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the SEC-DED codeword encoder.
// Mode encodings, data/check-bit counts per mode, codeword widths and the
// column-code helper used by the parity generator.
package ecc_pkg;

    typedef enum logic [1:0] {
        MODE_SMALL   = 2'b00,
        MODE_MEDIUM  = 2'b01,
        MODE_LARGE   = 2'b10,
        MODE_ILLEGAL = 2'b11
    } cw_mode_e;

    localparam int unsigned K_SMALL  = 4;
    localparam int unsigned K_MEDIUM = 11;
    localparam int unsigned K_LARGE  = 26;

    localparam int unsigned R_SMALL  = 3;
    localparam int unsigned R_MEDIUM = 4;
    localparam int unsigned R_LARGE  = 5;

    localparam int unsigned CW_W_SMALL  = K_SMALL  + R_SMALL  + 1;
    localparam int unsigned CW_W_MEDIUM = K_MEDIUM + R_MEDIUM + 1;
    localparam int unsigned CW_W_LARGE  = K_LARGE  + R_LARGE  + 1;

    localparam int unsigned K_MAX = K_LARGE;
    localparam int unsigned R_MAX = R_LARGE;

    // Number of data bits carried by a mode (0 for the illegal mode).
    function automatic logic [31:0] data_bits(input logic [1:0] mode);
        case (mode)
            MODE_SMALL:  return K_SMALL;
            MODE_MEDIUM: return K_MEDIUM;
            MODE_LARGE:  return K_LARGE;
            default:     return 32'd0;
        endcase
    endfunction

    // Number of Hamming check bits for a mode (overall parity excluded).
    function automatic logic [31:0] check_bits(input logic [1:0] mode);
        case (mode)
            MODE_SMALL:  return R_SMALL;
            MODE_MEDIUM: return R_MEDIUM;
            MODE_LARGE:  return R_LARGE;
            default:     return 32'd0;
        endcase
    endfunction

    // Mask keeping only the data bits a mode actually encodes.
    function automatic logic [31:0] data_mask(input logic [1:0] mode);
        return (32'd1 << data_bits(mode)) - 32'd1;
    endfunction

    // Column code of data bit idx: the (idx+1)-th integer >= 3 that is not
    // a power of two (3, 5, 6, 7, 9, ...).
    function automatic logic [4:0] col_code(input int unsigned idx);
        logic [4:0]  res;
        int unsigned cnt;
        res = '0;
        cnt = 0;
        for (int unsigned v = 3; v < 32; v++) begin
            if ((v & (v - 1)) != 0) begin
                if (cnt == idx) res = 5'(v);
                cnt++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ecc_parity_gen.sv
// ecc_parity_gen: combinational SEC-DED codeword builder.
// Layout: data at [K-1:0], check bit Cj at K+j, overall parity at K+r,
// everything above zero. Illegal mode yields an all-zero codeword.
module ecc_parity_gen
    import ecc_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_mode,
    output logic [31:0] o_cw
);

    logic [31:0] w_k;
    logic [31:0] w_r;
    logic [31:0] w_data;
    logic [4:0]  w_code;
    logic [4:0]  w_chk;
    logic        w_par;
    logic [31:0] w_cw;

    // Check bits from masked data, then place checks and overall parity.
    always_comb begin
        w_k    = data_bits(i_mode);
        w_r    = check_bits(i_mode);
        w_data = i_data & data_mask(i_mode);
        w_code = '0;
        w_chk  = '0;
        // Masked-off data bits are zero, so every column can be visited
        // and check bits at or above r stay zero for the shorter modes.
        for (int unsigned i = 0; i < K_MAX; i++) begin
            w_code = col_code(i);
            for (int unsigned j = 0; j < R_MAX; j++) begin
                if (w_code[j[2:0]] && w_data[i[4:0]]) begin
                    w_chk[j[2:0]] = ~w_chk[j[2:0]];
                end
            end
        end
        w_par = (^w_data) ^ (^w_chk);
        w_cw  = w_data;
        for (int unsigned j = 0; j < R_MAX; j++) begin
            if (j < w_r) w_cw[5'(w_k + j)] = w_chk[j[2:0]];
        end
        w_cw[5'(w_k + w_r)] = w_par;
        if (i_mode == MODE_ILLEGAL) w_cw = '0;
        o_cw = w_cw;
    end

endmodule

// File: rtl/ecc_encoder.sv
// ecc_encoder: 2-stage valid/ready SEC-DED encoder with delivered-word counter.
// Stage 1 registers masked data and mode, stage 2 registers the codeword.
// Optional build macro ECC_NOISE_EN adds a noise_mask input XORed into the
// codeword when stage 2 loads.
module ecc_encoder
    import ecc_pkg::*;
#(
    parameter int AMBA_WORD = 32,
    parameter int CNT_WIDTH = 16
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AMBA_WORD-1:0] data_in,
    input  logic [1:0]           cw_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AMBA_WORD-1:0] cw_out,
    output logic [1:0]           out_mode,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] enc_count
`ifdef ECC_NOISE_EN
    ,
    input  logic [AMBA_WORD-1:0] noise_mask
`endif
);

    logic                 r_s1_valid;
    logic [AMBA_WORD-1:0] r_s1_data;
    logic [1:0]           r_s1_mode;
    logic                 r_s2_valid;
    logic [AMBA_WORD-1:0] r_s2_cw;
    logic [1:0]           r_s2_mode;
    logic                 r_s2_illegal;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic                 w_s2_ready;
    logic                 w_s1_adv;
    logic                 w_accept;
    logic                 w_deliver;
    logic [AMBA_WORD-1:0] w_cw;

    ecc_parity_gen u_parity (
        .i_data (r_s1_data),
        .i_mode (r_s1_mode),
        .o_cw   (w_cw)
    );

    // Handshake: stage 2 frees when empty or draining; stage 1 follows it.
    // in_ready reduces to !s1_valid || !s2_valid || out_ready outside reset.
    always_comb begin
        w_s2_ready = !r_s2_valid || out_ready;
        w_s1_adv   = r_s1_valid && w_s2_ready;
        in_ready   = !rst && (!r_s1_valid || w_s2_ready);
        w_accept   = in_valid && in_ready;
        w_deliver  = r_s2_valid && out_ready;
    end

    // Stage 1: capture masked data and mode on accept, empty when it advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= data_in & data_mask(cw_mode);
            r_s1_mode  <= cw_mode;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: load codeword from stage 1, hold it until downstream takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_s2_cw      <= '0;
            r_s2_mode    <= '0;
            r_s2_illegal <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid   <= 1'b1;
`ifdef ECC_NOISE_EN
            r_s2_cw      <= w_cw ^ noise_mask;
`else
            r_s2_cw      <= w_cw;
`endif
            r_s2_mode    <= r_s1_mode;
            r_s2_illegal <= (r_s1_mode == MODE_ILLEGAL);
        end else if (w_deliver) begin
            r_s2_valid   <= 1'b0;
        end
    end

    // Delivered-word counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_deliver && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign out_valid = r_s2_valid;
    assign cw_out    = r_s2_cw;
    assign out_mode  = r_s2_mode;
    assign illegal   = r_s2_valid && r_s2_illegal;
    assign enc_count = r_cnt;

endmodule

// File: tb/tb_ecc_encoder.sv
// tb_ecc_encoder: table-driven vectors plus hand-written sequences for
// latency, random stalls and reset with words in flight. Expected
// codewords come from constants or an independent reference encoder and
// are pushed into a scoreboard queue when the DUT accepts each word.
module tb_ecc_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [1:0]  cw_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] cw_out;
    logic [1:0]  out_mode;
    logic        illegal;
    logic [15:0] enc_count;
`ifdef ECC_NOISE_EN
    logic [31:0] noise_mask;
`endif

    ecc_encoder #(.AMBA_WORD(32), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .cw_mode   (cw_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cw_out    (cw_out),
        .out_mode  (out_mode),
        .illegal   (illegal),
        .enc_count (enc_count)
`ifdef ECC_NOISE_EN
        ,
        .noise_mask(noise_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cw;
        logic [1:0]  mode;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] data;
        logic [31:0] cw;
        logic        ill;
    } vec_t;

    exp_t sb[$];
    int   ntests = 0;
    int   nfail  = 0;
    int   exp_cnt = 0;
    bit   rand_mode = 0;

    bit          prev_stall = 0;
    logic [31:0] prev_cw;
    logic [1:0]  prev_mode;
    logic        prev_ill;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference SEC-DED encoder: check bits are the XOR of the column codes
    // of the set data bits.
    function automatic logic [31:0] ref_enc(input logic [1:0] m, input logic [31:0] d);
        int k;
        int r;
        int code;
        logic [31:0] cw;
        logic [4:0]  chk;
        case (m)
            2'b00: begin k = 4;  r = 3; end
            2'b01: begin k = 11; r = 4; end
            2'b10: begin k = 26; r = 5; end
            default: return 32'h0;
        endcase
        cw = '0;
        chk = '0;
        code = 2;
        for (int i = 0; i < k; i++) begin
            code++;
            while ((code & (code - 1)) == 0) code++;
            if (((d >> i) & 32'd1) != 0) begin
                cw  = cw | (32'd1 << i);
                chk = chk ^ 5'(code);
            end
        end
        cw = cw | (32'(chk) << k);
        cw = cw | (32'(^cw) << (k + r));
        return cw;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [1:0] m, input logic [31:0] d,
                        input logic [31:0] ecw, input logic eill, output int waits);
        int   n;
        bit   done;
        exp_t e;
        in_valid = 1'b1;
        cw_mode  = m;
        data_in  = d;
        n = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.cw = ecw;
                e.mode = m;
                e.ill = eill;
                sb.push_back(e);
                done = 1;
            end else if (n >= 100) begin
                ntests++;
                nfail++;
                $display("FAIL accept_timeout: got no in_ready within %0d cycles, required accept", n);
                done = 1;
            end else begin
                n++;
            end
            tick();
        end
        in_valid = 1'b0;
        waits = n;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard / protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        check("enc_count", 32'(enc_count), 32'(exp_cnt));
        if (prev_stall) begin
            check("stall_hold", {out_valid, illegal, out_mode, cw_out[27:0]},
                  {1'b1, prev_ill, prev_mode, prev_cw[27:0]});
            check("stall_hold_hi", 32'(cw_out[31:28]), 32'(prev_cw[31:28]));
        end
        if (rst) begin
            sb.delete();
            exp_cnt = 0;
            prev_stall = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    ntests++;
                    nfail++;
                    $display("FAIL unexpected_word: got cw %h mode %0d, required no word", cw_out, out_mode);
                end else begin
                    e = sb.pop_front();
                    check("sb_cw", cw_out, e.cw);
                    check("sb_mode_ill", {29'd0, out_mode, illegal}, {29'd0, e.mode, e.ill});
                end
                exp_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_cw    = cw_out;
            prev_mode  = out_mode;
            prev_ill   = illegal;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[12];
        int   w;
        int   cnt0;
        logic [1:0]  m;
        logic [31:0] d;

        vecs[0]  = '{2'b00, 32'h0000000B, 32'h0000001B, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0};
        vecs[2]  = '{2'b10, 32'h00000001, 32'h8C000001, 1'b0};
        vecs[3]  = '{2'b10, 32'h03FFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{2'b11, 32'h12345678, 32'h00000000, 1'b1};
        vecs[5]  = '{2'b00, 32'h000000FF, 32'h000000FF, 1'b0};
        vecs[6]  = '{2'b00, 32'h00000001, 32'h000000B1, 1'b0};
        vecs[7]  = '{2'b01, 32'h00000001, 32'h00009801, 1'b0};
        vecs[8]  = '{2'b10, 32'h00000000, 32'h00000000, 1'b0};
        for (int i = 9; i < 12; i++) begin
            m = 2'($urandom_range(0, 2));
            d = $urandom;
            vecs[i] = '{m, d, ref_enc(m, d), 1'b0};
        end

        rst = 1'b1;
        in_valid = 1'b0;
        data_in = '0;
        cw_mode = '0;
        out_ready = 1'b1;
`ifdef ECC_NOISE_EN
        noise_mask = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_enc_count", 32'(enc_count), 32'd0);
        check("rst_cw_out", cw_out, 32'd0);
        check("rst_mode_ill", {29'd0, out_mode, illegal}, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();

        // Latency: accept edge, one cycle in stage 1, then out_valid.
        send(2'b00, 32'h0000000B, 32'h0000001B, 1'b0, w);
        check("lat_cycle1_invalid", 32'(out_valid), 32'd0);
        tick();
        check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        check("lat_cycle2_cw", cw_out, 32'h0000001B);
        wait_drain();

        // Table, back-to-back with out_ready high: no accept bubbles.
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].mode, vecs[i].data, vecs[i].cw, vecs[i].ill, w);
            check("throughput_waits", 32'(w), 32'd0);
        end
        wait_drain();

`ifdef ECC_NOISE_EN
        noise_mask = 32'h00000004;
        send(2'b10, 32'h00000000, 32'h00000004, 1'b0, w);
        wait_drain();
        noise_mask = '0;
`endif

        // Ten words with randomly toggling out_ready.
        cnt0 = exp_cnt;
        rand_mode = 1;
        for (int i = 0; i < 10; i++) begin
            m = 2'($urandom_range(0, 2));
            d = $urandom;
            send(m, d, ref_enc(m, d), 1'b0, w);
        end
        wait_drain();
        rand_mode = 0;
        out_ready = 1'b1;
        check("ten_word_count", 32'(enc_count), 32'(cnt0 + 10));

        // Reset with two words in flight.
        out_ready = 1'b0;
        send(2'b00, 32'h0000000B, 32'h0000001B, 1'b0, w);
        send(2'b01, 32'h00000001, 32'h00009801, 1'b0, w);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("inflight_rst_valid", 32'(out_valid), 32'd0);
        check("inflight_rst_count", 32'(enc_count), 32'd0);
        check("inflight_rst_cw", cw_out, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_stale_word", 32'(out_valid), 32'd0);
        end
        send(2'b00, 32'h00000001, 32'h000000B1, 1'b0, w);
        wait_drain();
        check("post_rst_count", 32'(enc_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/ecc_encoder.md
ECC_ENCODER -- requirements
Module: ecc_encoder

Interface
REQ-001 SHALL have parameter AMBA_WORD, default 32, codeword/data bus width (only 32 supported).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the encoded-word counter.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, data_in/cw_mode valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts a word this cycle.
REQ-007 SHALL have port data_in, input, AMBA_WORD, raw data, LSB-aligned.
REQ-008 SHALL have port cw_mode, input, 2, 00 small (8b), 01 medium (16b), 10 large (32b), 11 illegal.
REQ-009 SHALL have port out_valid, input-paired output, 1, cw_out valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts cw_out.
REQ-011 SHALL have port cw_out, output, AMBA_WORD, encoded codeword.
REQ-012 SHALL have port out_mode, output, 2, cw_mode travelling with cw_out.
REQ-013 SHALL have port illegal, output, 1, high with out_valid when word carried mode 11.
REQ-014 SHALL have port enc_count, output, CNT_WIDTH, count of codewords delivered.

Function
REQ-015 SHALL encode K data bits (small 4, medium 11, large 26) with r check bits (3/4/5) plus one overall parity bit; data_in bits at or above K ignored.
REQ-016 SHALL assign data bit i the (i+1)-th integer >=3 that is not a power of two as its column code; check bit Cj = XOR of data bits whose code has bit j set.
REQ-017 SHALL lay out codeword: data at [K-1:0], Cj at bit K+j, overall parity P (XOR of all data and check bits) at bit K+r; bits above K+r zero.
REQ-018 SHALL implement a 2-stage valid/ready pipeline: stage 1 registers masked data and mode; stage 2 registers codeword, mode, illegal.
REQ-019 SHALL have latency 2 cycles from accept (in_valid&&in_ready) to out_valid with out_ready held high; throughput 1 word/cycle.
REQ-020 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready, combinationally, no bubble when downstream ready.
REQ-021 SHALL hold cw_out, out_mode, illegal stable while out_valid && !out_ready; no word lost or duplicated under any stall pattern.
REQ-022 SHALL, for cw_mode 11, accept the word, output cw_out all-zero, out_mode 11, illegal=1.
REQ-023 SHALL increment enc_count on each out_valid&&out_ready (illegal words included), saturating at all-ones.
REQ-024 SHALL give simultaneous accept and deliver in one cycle: both take effect, pipeline occupancy unchanged.

Reset
REQ-025 SHALL, when rst high at a clock edge, clear s1_valid, s2_valid, out_valid, illegal, cw_out, out_mode, enc_count to zero; words in flight are discarded.
REQ-026 SHALL hold in_ready low during any cycle rst is high.

Configuration
REQ-027 SHALL, with ECC_NOISE_EN defined, add input noise_mask (AMBA_WORD), sampled at stage-2 load, XORed into cw_out (for decoder test injection).
REQ-028 SHALL, without ECC_NOISE_EN, omit noise_mask port and logic; cw_out is the pure codeword.

Structure
REQ-029 SHALL place in shared package ecc_pkg: mode encodings, K/r per mode, codeword widths, column-code function.
REQ-030 SHALL put parity computation in combinational sub-module ecc_parity_gen (data, mode -> codeword); ecc_encoder holds pipeline, handshake, counter.

Verification
REQ-031 SHALL cover: small, data_in=32'h0000000B -> cw_out=32'h0000001B after 2 cycles.
REQ-032 SHALL cover: medium, data_in=32'hFFFFFFFF -> cw_out=32'h0000FFFF; large, data_in=32'h00000001 -> 32'h8C000001; large, 32'h03FFFFFF -> 32'hFFFFFFFF.
REQ-033 SHALL cover: 10 back-to-back words, out_ready toggling random -> all 10 delivered in order, unchanged while stalled, enc_count=10.
REQ-034 SHALL cover: cw_mode=11 data 32'h12345678 -> cw_out=0, out_mode=11, illegal=1.
REQ-035 SHALL cover: rst asserted with 2 words in flight -> next cycle out_valid=0, enc_count=0, no stale word after release.
REQ-036 SHALL cover (ECC_NOISE_EN): large, data 0, noise_mask=32'h00000004 -> cw_out=32'h00000004.
